// File: rtl/line_fill_responder.sv
// line_fill_responder: backing-store responder below the data cache.
// Serves line refill (read) and writeback (write) bursts from a word-addressed
// array; read beats start a fixed LATENCY cycles after request acceptance.
module line_fill_responder #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic        wdata_valid,
    input  logic [31:0] wdata,
    output logic        wdata_ready,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        rdata_last,
    output logic        wr_done
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned TAG_W = ADDR_WIDTH - OFF_W;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, READ, WRITE} stateT;

    logic [31:0]           mem [DEPTH];
    stateT                 state;
    logic [TAG_W-1:0]      lineTag;
    logic [OFF_W-1:0]      beat;
    logic [CNT_W-1:0]      latCnt;
    logic [ADDR_WIDTH-1:0] beatAddr;
    logic                  writeFire;
    logic                  unusedAddr;

    // Beat index fills the offset bits only, so a burst never leaves its line.
    assign beatAddr  = {lineTag, beat};
    // Accepted write beat; a reset cycle suppresses the store.
    assign writeFire = wdata_valid & wdata_ready & ~rst;
    // Byte-offset and aliased upper address bits are intentionally dropped.
    assign unusedAddr = ^req_addr;

    // Array storage: not reset, written on each accepted write beat.
    always_ff @(posedge clk) begin
        if (writeFire) begin
            mem[beatAddr] <= wdata;
        end
    end

    // Control FSM with registered handshake and read-beat outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            wdata_ready <= 1'b0;
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            wr_done     <= 1'b0;
            rdata       <= 32'd0;
            lineTag     <= '0;
            beat        <= '0;
            latCnt      <= '0;
        end else begin
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            wr_done     <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        lineTag   <= req_addr[ADDR_WIDTH+1:OFF_W+2];
                        beat      <= '0;
                        req_ready <= 1'b0;
                        if (req_write) begin
                            state       <= WRITE;
                            wdata_ready <= 1'b1;
                        end else if (LATENCY == 1) begin
                            state <= READ;
                        end else begin
                            state  <= WAIT;
                            latCnt <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (latCnt == CNT_W'(1)) begin
                        state <= READ;
                    end else begin
                        latCnt <= latCnt - 1'b1;
                    end
                end
                READ: begin
                    rdata_valid <= 1'b1;
                    rdata       <= mem[beatAddr];
                    beat        <= beat + 1'b1;
                    if (beat == OFF_W'(LINE_WORDS - 1)) begin
                        rdata_last <= 1'b1;
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wdata_valid && wdata_ready) begin
                        beat <= beat + 1'b1;
                        if (beat == OFF_W'(LINE_WORDS - 1)) begin
                            state       <= IDLE;
                            wdata_ready <= 1'b0;
                            wr_done     <= 1'b1;
                            req_ready   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_responder.sv
// Testbench for line_fill_responder: scoreboard of expected read beats fed
// from a word-level memory model, plus latency/line-size sweep instances.
module tb_line_fill_responder;

    localparam int unsigned AW  = 16;
    localparam int unsigned LW  = 4;
    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst, reqValid, reqWrite, wdataValid;
    logic [31:0] reqAddr, wdata;
    logic        reqReady, wdataReady, rdataValid, rdataLast, wrDone;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;
    int wrBeats = 0;
    int wrDonePulses = 0;

    logic [31:0] model [int];
    logic [31:0] expQ [$];
    logic [31:0] gotData [$];
    logic        gotLast [$];
    int          gotCyc [$];

    // Sweep instances: (LINE_WORDS, LATENCY) = (2,1), (8,2), (4,5)
    logic [2:0]  swReqValid, swReqWrite, swWdataValid;
    logic [2:0]  swReqReady, swWdataReady, swRdataValid, swRdataLast, swWrDone;
    logic [31:0] swReqAddr [3];
    logic [31:0] swWdata [3];
    logic [31:0] swRdata [3];

    always #5 clk = ~clk;

    line_fill_responder #(.ADDR_WIDTH(AW), .LINE_WORDS(LW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(reqReady),
        .req_write(reqWrite), .req_addr(reqAddr), .wdata_valid(wdataValid),
        .wdata(wdata), .wdata_ready(wdataReady), .rdata_valid(rdataValid),
        .rdata(rdata), .rdata_last(rdataLast), .wr_done(wrDone)
    );

    for (genvar g = 0; g < 3; g++) begin : gSweep
        localparam int unsigned GLW  = (g == 0) ? 2 : (g == 1) ? 8 : 4;
        localparam int unsigned GLAT = (g == 0) ? 1 : (g == 1) ? 2 : 5;
        line_fill_responder #(.ADDR_WIDTH(8), .LINE_WORDS(GLW), .LATENCY(GLAT)) uSw (
            .clk(clk), .rst(rst), .req_valid(swReqValid[g]), .req_ready(swReqReady[g]),
            .req_write(swReqWrite[g]), .req_addr(swReqAddr[g]), .wdata_valid(swWdataValid[g]),
            .wdata(swWdata[g]), .wdata_ready(swWdataReady[g]), .rdata_valid(swRdataValid[g]),
            .rdata(swRdata[g]), .rdata_last(swRdataLast[g]), .wr_done(swWrDone[g])
        );
    end

    // Event counters for write beats taken and wr_done cycles.
    always @(posedge clk) begin
        if (wdataValid && wdataReady) wrBeats++;
        if (wrDone) wrDonePulses++;
    end

    function automatic int swLw(input int k);
        return (k == 0) ? 2 : (k == 1) ? 8 : 4;
    endfunction

    function automatic int swLat(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 5;
    endfunction

    function automatic int lineKey(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << AW) - 1) & ~(LW - 1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startReq(input logic wr, input logic [31:0] a);
        int n;
        n = 0;
        while (!reqReady && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_timeout: got %b want 1", reqReady);
        end
        reqWrite = wr;
        reqAddr  = a;
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        reqWrite = 1'b0;
    endtask

    task automatic writeBurst(input logic [31:0] a, input logic [31:0] first, input bit gap);
        int k;
        k = lineKey(a);
        startReq(1'b1, a);
        for (int i = 0; i < int'(LW); i++) begin
            if (gap) begin
                wdataValid = 1'b0;
                wdata      = 32'hDEAD_0000 + 32'(i);
                tick();
            end
            wdataValid = 1'b1;
            wdata      = first + 32'(i);
            model[k + i] = first + 32'(i);
            tick();
        end
        wdataValid = 1'b0;
    endtask

    task automatic issueRead(input logic [31:0] a);
        int k;
        k = lineKey(a);
        for (int i = 0; i < int'(LW); i++) expQ.push_back(model[k + i]);
        startReq(1'b0, a);
    endtask

    task automatic collect(input int ncyc);
        gotData.delete();
        gotLast.delete();
        gotCyc.delete();
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (rdataValid) begin
                gotData.push_back(rdata);
                gotLast.push_back(rdataLast);
                gotCyc.push_back(c);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reqValid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({reqReady, wdataReady, rdataValid, rdataLast, wrDone, rdata} !== 37'd0) begin
                errors++;
                $display("FAIL reset_outputs: got %h want 0",
                         {reqReady, wdataReady, rdataValid, rdataLast, wrDone, rdata});
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (reqReady !== 1'b1 || wdataReady !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_reset: got %b%b want 10", reqReady, wdataReady);
        end
        reqValid = 1'b0;
        tick();
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("FAIL no_accept_in_reset: got %b want 1", reqReady);
        end
    endtask

    task automatic test_write_then_read();
        int b0, p0;
        logic [31:0] e;
        b0 = wrBeats;
        p0 = wrDonePulses;
        writeBurst(32'h0000_0104, 32'hA0, 1'b0);
        checks++;
        if (wrDone !== 1'b1 || reqReady !== 1'b1) begin
            errors++;
            $display("FAIL wr_done_ready: got %b%b want 11", wrDone, reqReady);
        end
        checks++;
        if (wrBeats - b0 != 4) begin
            errors++;
            $display("FAIL write_beats: got %0d want 4", wrBeats - b0);
        end
        issueRead(32'h0000_010C);
        checks++;
        if (reqReady !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_accept: got %b want 0", reqReady);
        end
        collect(int'(LAT + LW + 2));
        checks++;
        if (gotData.size() != int'(LW)) begin
            errors++;
            $display("FAIL wr_rd_beats: got %0d want %0d", gotData.size(), LW);
        end
        for (int i = 0; i < gotData.size(); i++) begin
            e = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (gotData[i] !== e || gotData[i] !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL wr_rd_data: got %h want %h", gotData[i], 32'hA0 + 32'(i));
            end
            checks++;
            if (gotLast[i] !== (i == int'(LW) - 1) || gotCyc[i] != int'(LAT) + i) begin
                errors++;
                $display("FAIL wr_rd_timing: got last=%b cyc=%0d want last=%b cyc=%0d",
                         gotLast[i], gotCyc[i], (i == int'(LW) - 1), int'(LAT) + i);
            end
        end
        expQ.delete();
        checks++;
        if (wrDonePulses - p0 != 1 || reqReady !== 1'b1) begin
            errors++;
            $display("FAIL wr_done_pulses: got %0d ready=%b want 1 ready=1",
                     wrDonePulses - p0, reqReady);
        end
    endtask

    task automatic test_gapped_write();
        int b0;
        logic [31:0] e;
        b0 = wrBeats;
        writeBurst(32'h0000_0104, 32'hB0, 1'b1);
        checks++;
        if (wrDone !== 1'b1 || wrBeats - b0 != 4) begin
            errors++;
            $display("FAIL gapped_write: got done=%b beats=%0d want done=1 beats=4",
                     wrDone, wrBeats - b0);
        end
        wdataValid = 1'b1;
        wdata = 32'hFFFF_FFFF;
        tick();
        tick();
        wdataValid = 1'b0;
        checks++;
        if (wrBeats - b0 != 4) begin
            errors++;
            $display("FAIL stray_wdata: got %0d want 4", wrBeats - b0);
        end
        issueRead(32'h0000_0100);
        collect(int'(LAT + LW + 2));
        checks++;
        if (gotData.size() != int'(LW)) begin
            errors++;
            $display("FAIL gapped_beats: got %0d want %0d", gotData.size(), LW);
        end
        for (int i = 0; i < gotData.size(); i++) begin
            e = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (gotData[i] !== e) begin
                errors++;
                $display("FAIL gapped_data: got %h want %h", gotData[i], e);
            end
        end
        expQ.delete();
    endtask

    task automatic test_alias();
        logic [31:0] e;
        writeBurst(32'h0004_0000, 32'hC0, 1'b0);
        tick();
        issueRead(32'h0000_000B);
        collect(int'(LAT + LW + 2));
        checks++;
        if (gotData.size() != int'(LW)) begin
            errors++;
            $display("FAIL alias_beats: got %0d want %0d", gotData.size(), LW);
        end
        for (int i = 0; i < gotData.size(); i++) begin
            e = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (gotData[i] !== e || gotData[i] !== 32'hC0 + 32'(i)) begin
                errors++;
                $display("FAIL alias_data: got %h want %h", gotData[i], 32'hC0 + 32'(i));
            end
        end
        expQ.delete();
    endtask

    task automatic test_reset_mid_read();
        int n;
        logic [31:0] e;
        tick();
        issueRead(32'h0000_0100);
        n = 0;
        while (!rdataValid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (rdataValid !== 1'b1 || rdata !== expQ[0]) begin
            errors++;
            $display("FAIL mid_read_beat0: got %b/%h want 1/%h", rdataValid, rdata, expQ[0]);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (rdataValid !== 1'b0 || rdataLast !== 1'b0 || reqReady !== 1'b0 || wrDone !== 1'b0) begin
            errors++;
            $display("FAIL mid_read_reset: got %b%b%b%b want 0000",
                     rdataValid, rdataLast, reqReady, wrDone);
        end
        expQ.delete();
        tick();
        checks++;
        if (reqReady !== 1'b1 || rdataValid !== 1'b0) begin
            errors++;
            $display("FAIL mid_read_recover: got %b%b want 10", reqReady, rdataValid);
        end
        issueRead(32'h0000_0100);
        collect(int'(LAT + LW + 2));
        checks++;
        if (gotData.size() != int'(LW)) begin
            errors++;
            $display("FAIL reread_beats: got %0d want %0d", gotData.size(), LW);
        end
        for (int i = 0; i < gotData.size(); i++) begin
            e = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (gotData[i] !== e || gotCyc[i] != int'(LAT) + i) begin
                errors++;
                $display("FAIL reread_data: got %h@%0d want %h@%0d",
                         gotData[i], gotCyc[i], e, int'(LAT) + i);
            end
        end
        expQ.delete();
    endtask

    task automatic test_latency_sweep();
        int lw, lat, n, got;
        logic [31:0] e;
        for (int k = 0; k < 3; k++) begin
            lw  = swLw(k);
            lat = swLat(k);
            n = 0;
            while (!swReqReady[k] && n < 50) begin
                tick();
                n++;
            end
            swReqWrite[k] = 1'b1;
            swReqAddr[k]  = 32'h40;
            swReqValid[k] = 1'b1;
            tick();
            swReqValid[k] = 1'b0;
            swReqWrite[k] = 1'b0;
            for (int i = 0; i < lw; i++) begin
                swWdataValid[k] = 1'b1;
                swWdata[k] = 32'h5000_0000 + 32'(k << 8) + 32'(i);
                expQ.push_back(swWdata[k]);
                tick();
            end
            swWdataValid[k] = 1'b0;
            checks++;
            if (swWrDone[k] !== 1'b1 || swReqReady[k] !== 1'b1) begin
                errors++;
                $display("FAIL sweep%0d_wr_done: got %b%b want 11", k, swWrDone[k], swReqReady[k]);
            end
            swReqAddr[k]  = 32'h44;
            swReqValid[k] = 1'b1;
            tick();
            swReqValid[k] = 1'b0;
            got = 0;
            for (int c = 1; c <= lat + lw + 2; c++) begin
                tick();
                if (swRdataValid[k]) begin
                    e = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
                    checks++;
                    if (swRdata[k] !== e) begin
                        errors++;
                        $display("FAIL sweep%0d_data: got %h want %h", k, swRdata[k], e);
                    end
                    checks++;
                    if (c != lat + got || swRdataLast[k] !== (got == lw - 1)) begin
                        errors++;
                        $display("FAIL sweep%0d_timing: got cyc=%0d last=%b want cyc=%0d last=%b",
                                 k, c, swRdataLast[k], lat + got, (got == lw - 1));
                    end
                    got++;
                end
            end
            checks++;
            if (got != lw) begin
                errors++;
                $display("FAIL sweep%0d_count: got %0d want %0d", k, got, lw);
            end
            expQ.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqAddr = 32'd0;
        wdataValid = 1'b0;
        wdata = 32'd0;
        swReqValid = '0;
        swReqWrite = '0;
        swWdataValid = '0;
        for (int i = 0; i < 3; i++) begin
            swReqAddr[i] = 32'd0;
            swWdata[i] = 32'd0;
        end
        test_reset();
        test_write_then_read();
        test_gapped_write();
        test_alias();
        test_reset_mid_read();
        test_latency_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
